// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Shared types for the UART transmit feeder: the byte type and the
//   feeder FSM state encoding.
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_RISE = 2'd2,
    WAIT_FALL = 2'd3
  } tx_state_e;

endpackage

// File: rtl/byte_fifo.sv
// ---------------------------------------------------------------------------
// byte_fifo
//   Synchronous byte FIFO with wrapping read/write pointers and an occupancy
//   counter. Storage is not reset; only pointers and count are.
//
//   clk, rst      clock, synchronous active-high reset
//   push_i        write push_data_i (ignored when full)
//   push_data_i   byte to store
//   pop_i         drop the head entry (ignored when empty)
//   head_o        current head entry
//   count_o       entries held, 0..DEPTH
//   full_o        count_o == DEPTH (registered-state only)
// ---------------------------------------------------------------------------
import uart_pkg::*;

module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  byte_t                    push_data_i,
  input  logic                     pop_i,
  output byte_t                    head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  byte_t          mem_q [DEPTH];
  logic [AW-1:0]  wr_q, rd_q;
  logic [CW-1:0]  cnt_q;
  logic           do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && (cnt_q != '0);
  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      // simultaneous push and pop leaves the count alone
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_data_i;
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// ---------------------------------------------------------------------------
// uart_tx_feeder
//   Buffers bytes from a producer and hands them one at a time to a UART
//   transmit model using a start pulse / busy handshake. Keeps a count of
//   completed bytes.
//
//   clk, rst     clock, synchronous active-high reset
//   in_valid     producer offers in_data
//   in_data      producer byte
//   in_ready     a byte can be accepted (FIFO not full)
//   start        one-cycle launch pulse to the transmitter
//   data         launched byte, held until the next launch
//   busy         transmitter busy
//   fifo_count   bytes queued
//   sent_count   completed bytes, wraps mod 2^16
//   idle         FSM idle and FIFO empty
// ---------------------------------------------------------------------------
import uart_pkg::*;

module uart_tx_feeder #(
  parameter int DEPTH     = 16,
  parameter int RISE_WAIT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  output logic                   in_ready,
  output logic                   start,
  output logic [7:0]             data,
  input  logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [15:0]            sent_count,
  output logic                   idle
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int WW = (RISE_WAIT > 1) ? $clog2(RISE_WAIT) : 1;

  tx_state_e      state_q;
  logic           start_q;
  byte_t          data_q;
  logic [WW-1:0]  wcnt_q;
  logic [15:0]    sent_q, sent_d;

  byte_t          fifo_head;
  logic [CW-1:0]  fifo_cnt;
  logic           fifo_full;
  logic           fifo_push, fifo_pop;

  // Acceptance depends only on the registered count, so a pop on the same
  // edge cannot open a slot for a byte while full.
  assign in_ready  = !fifo_full;
  assign fifo_push = in_valid && in_ready;
  // LAUNCH is only entered with a non-empty FIFO.
  assign fifo_pop  = (state_q == LAUNCH);

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (fifo_push),
    .push_data_i (in_data),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .count_o     (fifo_cnt),
    .full_o      (fifo_full)
  );

  // Launch FSM; start and data are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      data_q  <= '0;
      wcnt_q  <= '0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if ((fifo_cnt != '0) && !busy) state_q <= LAUNCH;
        end
        LAUNCH: begin
          start_q <= 1'b1;
          data_q  <= fifo_head;
          wcnt_q  <= '0;
          state_q <= WAIT_RISE;
        end
        WAIT_RISE: begin
          // a transmitter that never raises busy must not stall the queue
          if (busy || (wcnt_q == WW'(RISE_WAIT - 1))) state_q <= WAIT_FALL;
          else                                        wcnt_q  <= wcnt_q + WW'(1);
        end
        WAIT_FALL: begin
          if (!busy) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Completion counter, written every cycle from its next-state value.
  always_comb begin
    sent_d = sent_q;
    if ((state_q == WAIT_FALL) && !busy) sent_d = sent_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) sent_q <= '0;
    else     sent_q <= sent_d;
  end

  assign start      = start_q;
  assign data       = data_q;
  assign fifo_count = fifo_cnt;
  assign sent_count = sent_q;
  assign idle       = (state_q == IDLE) && (fifo_cnt == '0);

endmodule

// File: tb/tb_uart_tx_feeder.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_feeder
//   Scoreboard bench: the driver queues every byte the feeder should accept,
//   a negedge monitor pops on each start pulse and checks byte order, FIFO
//   occupancy, in_ready and sent_count. A small transmitter model drives busy.
// ---------------------------------------------------------------------------
module tb_uart_tx_feeder;

  localparam int DEPTH     = 16;
  localparam int RISE_WAIT = 4;
  localparam int CW        = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          busy = 1'b0;
  logic          in_ready, start, idle;
  logic [7:0]    data;
  logic [CW-1:0] fifo_count;
  logic [15:0]   sent_count;

  uart_tx_feeder #(.DEPTH(DEPTH), .RISE_WAIT(RISE_WAIT)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .start      (start),
    .data       (data),
    .busy       (busy),
    .fifo_count (fifo_count),
    .sent_count (sent_count),
    .idle       (idle)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  exp_q[$];
  int          model_cnt = 0;
  logic [15:0] n_start = 16'd0;
  int          ncyc = 0;
  int          start_neg = 0;
  int          push_neg = 0;
  logic        start_prev = 1'b0;
  // transmitter model: 0 = busy tied low, 1 = normal, 2 = busy held high
  int          bmode = 0;
  int          bdly = 3;
  int          blen = 20;
  int          b_cd = 0;
  int          b_hi = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp_v, ncyc);
    end
  endtask

  // Monitor + transmitter model, both evaluated on the falling edge.
  initial forever begin
    @(negedge clk);
    ncyc++;
    if (start === 1'b1) begin
      chk("start_one_cycle", {31'd0, start_prev}, 32'd0);
      chk("busy_low_at_start", {31'd0, busy}, 32'd0);
      chk("sent_at_start", {16'd0, sent_count}, {16'd0, n_start});
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL spurious_start: got start with data %0h expected no start", data);
      end else begin
        chk("start_data", {24'd0, data}, {24'd0, exp_q.pop_front()});
        model_cnt--;
      end
      n_start++;
      start_neg = ncyc;
    end
    start_prev = start;
    chk("fifo_count", {{(32-CW){1'b0}}, fifo_count}, model_cnt);
    chk("in_ready", {31'd0, in_ready}, {31'd0, (model_cnt < DEPTH)});
    case (bmode)
      0: begin b_cd = 0; b_hi = 0; busy = 1'b0; end
      2: begin b_cd = 0; b_hi = 0; busy = 1'b1; end
      default: begin
        if (b_hi > 0) b_hi--;
        if (b_cd > 0) begin
          b_cd--;
          if (b_cd == 0) b_hi = blen;
        end
        if (start === 1'b1) b_cd = bdly;
        busy = (b_hi > 0);
      end
    endcase
  end

  task automatic idle_c();
    @(negedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic push(input logic [7:0] b);
    @(negedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = b;
    push_neg = ncyc;
    if (model_cnt < DEPTH) begin
      exp_q.push_back(b);
      model_cnt++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst      = 1'b1;
    in_valid = 1'b0;
    exp_q.delete();
    model_cnt = 0;
    n_start   = 16'd0;
    bmode     = 0;
    @(posedge clk);
    #1;
    chk("rst_start", {31'd0, start}, 32'd0);
    chk("rst_data", {24'd0, data}, 32'd0);
    chk("rst_fifo_count", {{(32-CW){1'b0}}, fifo_count}, 32'd0);
    chk("rst_sent_count", {16'd0, sent_count}, 32'd0);
    chk("rst_idle", {31'd0, idle}, 32'd1);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;
  endtask

  task automatic drain(input string nm);
    int t;
    t = 0;
    idle_c();
    while (!(exp_q.size() == 0 && idle === 1'b1) && t < 3000) begin
      idle_c();
      t++;
    end
    if (t >= 3000) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: got %0d bytes pending expected 0", nm, exp_q.size());
    end
    chk({nm, "_idle"}, {31'd0, idle}, 32'd1);
    chk({nm, "_sent"}, {16'd0, sent_count}, {16'd0, n_start});
  endtask

  initial begin
    logic [15:0] base;
    int          t;

    // reset state
    do_reset();

    // single byte, latency from accept edge to start
    bmode = 1; bdly = 3; blen = 20;
    push(8'hA5);
    drain("single");
    chk("single_latency", start_neg - push_neg, 32'd3);
    chk("single_sent_one", {16'd0, sent_count}, 32'd1);

    // back-to-back burst, order checked by the scoreboard
    bdly = 2; blen = 5;
    for (int i = 1; i <= 5; i++) push(8'(i));
    drain("burst");
    chk("burst_sent", {16'd0, sent_count}, 32'd6);

    // full: busy held high so nothing launches; two extra bytes dropped
    bmode = 2;
    idle_c();
    idle_c();
    for (int i = 0; i < DEPTH + 2; i++) push(8'(8'h40 + i));
    idle_c();
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    chk("full_count", {{(32-CW){1'b0}}, fifo_count}, DEPTH);
    bmode = 1; bdly = 1; blen = 3;
    drain("full_drain");

    // busy never rises: WAIT_RISE times out, then completes
    bmode = 0;
    base = n_start;
    push(8'h3C);
    t = 0;
    while (n_start == base && t < 20) begin
      idle_c();
      t++;
    end
    if (n_start == base) begin
      n_cmp++;
      n_err++;
      $display("FAIL norise_start: got no start expected one");
    end
    repeat (RISE_WAIT) idle_c();
    chk("norise_hold", {16'd0, sent_count}, {16'd0, base});
    idle_c();
    chk("norise_done", {16'd0, sent_count}, {16'd0, base + 16'd1});
    drain("norise");

    // reset while waiting for busy to fall with bytes still queued
    bmode = 1; bdly = 1; blen = 20;
    for (int i = 0; i < 4; i++) push(8'(8'hC0 + i));
    t = 0;
    while (busy !== 1'b1 && t < 30) begin
      idle_c();
      t++;
    end
    chk("midrst_busy_seen", {31'd0, busy}, 32'd1);
    idle_c();
    idle_c();
    do_reset();
    bmode = 1;
    repeat (30) idle_c();
    chk("midrst_idle", {31'd0, idle}, 32'd1);
    chk("midrst_sent", {16'd0, sent_count}, 32'd0);

    // sent_count wrap from 0xFFFF
    @(negedge clk);
    #1;
    force dut.sent_q = 16'hFFFF;
    idle_c();
    idle_c();
    release dut.sent_q;
    n_start = 16'hFFFF;
    idle_c();
    chk("wrap_preload", {16'd0, sent_count}, 32'h0000FFFF);
    bdly = 2; blen = 4;
    push(8'h77);
    drain("wrap");
    chk("wrap_zero", {16'd0, sent_count}, 32'd0);

    // randomized traffic
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(4, 0) == 0) begin
        bdly = $urandom_range(3, 1);
        blen = $urandom_range(10, 1);
      end
      if ($urandom_range(99, 0) < 55) push(8'($urandom));
      else idle_c();
    end
    drain("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_tx_feeder.md
UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

Interface
REQ-001 Parameter DEPTH, default 16, FIFO depth in bytes; power of two, at least 2.
REQ-002 Parameter RISE_WAIT, default 4, maximum cycles to wait for busy to rise after a launch.
REQ-003 Reset is rst, synchronous, active-high; the clock is clk.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 in_valid  in  1  producer offers in_data this cycle.
REQ-007 in_data  in  8  byte offered by the producer.
REQ-008 in_ready  out  1  feeder can accept a byte this cycle.
REQ-009 start  out  1  one-cycle launch pulse to the UART transmit model.
REQ-010 data  out  8  byte to transmit; valid while start=1.
REQ-011 busy  in  1  transmitter busy, from the UART transmit model.
REQ-012 fifo_count  out  $clog2(DEPTH)+1  bytes currently queued.
REQ-013 sent_count  out  16  bytes completed since reset; wraps modulo 2^16.
REQ-014 idle  out  1  high when the FSM is in IDLE and fifo_count=0.

Function
REQ-015 in_ready SHALL equal (fifo_count < DEPTH) and be derived only from registered state.
REQ-016 A byte is pushed on any rising edge where in_valid=1 and in_ready=1; in_valid with in_ready=0 is ignored and the byte is not stored.
REQ-017 The FIFO SHALL be first-in, first-out, with wrapping read and write pointers; fifo_count SHALL update on the same edge as any push or pop.
REQ-018 A push and a pop on the same edge SHALL leave fifo_count unchanged.
REQ-019 When full, in_ready=0, even if a pop occurs on the same edge.
REQ-020 The FSM SHALL have four states: IDLE, LAUNCH, WAIT_RISE, WAIT_FALL.
REQ-021 IDLE -> LAUNCH when fifo_count>0 and busy=0; otherwise the FSM stays in IDLE.
REQ-022 In LAUNCH the FSM SHALL assert start=1 for exactly one cycle, drive data with the FIFO head, pop the head, and go to WAIT_RISE.
REQ-023 start and data SHALL be registered outputs; data SHALL hold the last launched byte until the next launch.
REQ-024 In WAIT_RISE, busy=1 SHALL take the FSM to WAIT_FALL; after RISE_WAIT cycles with busy=0, the FSM SHALL also go to WAIT_FALL.
REQ-025 In WAIT_FALL, busy=0 SHALL take the FSM to IDLE and increment sent_count by 1, wrapping 0xFFFF -> 0x0000.
REQ-026 Latency: a byte accepted on edge E into an empty FIFO, with the FSM in IDLE and busy=0, SHALL produce start=1 during the cycle after edge E+2.
REQ-027 There SHALL be at most one byte in flight; start SHALL never be asserted outside LAUNCH.
REQ-028 The producer MAY push at any time during LAUNCH, WAIT_RISE or WAIT_FALL.

Reset
REQ-029 On rst=1 the following SHALL be cleared: state=IDLE, start=0, data=0, FIFO pointers=0, fifo_count=0, sent_count=0; idle=1 and in_ready=1 after reset.
REQ-030 FIFO storage SHALL NOT be reset.
REQ-031 Reset mid-transfer SHALL discard all queued bytes, and start SHALL be 0 in the cycle following the reset edge.

Structure
REQ-032 A shared package uart_pkg SHALL hold the FSM state enum (IDLE, LAUNCH, WAIT_RISE, WAIT_FALL) and the byte typedef.
REQ-033 The FIFO SHALL be one sub-module, byte_fifo (parameter DEPTH; push/pop/count interface), instantiated once.
REQ-034 The FSM and sent_count logic SHALL be written in uart_tx_feeder itself.

Verification
REQ-035 Single byte: push 0xA5 with busy low, model busy high 3 cycles after start for 20 cycles -> one start pulse with data=0xA5 at the latency of REQ-026; sent_count=1; idle=1 afterwards.
REQ-036 Burst: push 0x01..0x05 back-to-back -> five start pulses in order 0x01..0x05, each only after busy has fallen; sent_count=5.
REQ-037 Full: push DEPTH+2 bytes while busy is held high -> in_ready=0 once fifo_count=DEPTH, the extra 2 bytes are dropped, fifo_count=DEPTH.
REQ-038 Missing busy: busy tied low, push 0x3C -> start pulse, WAIT_RISE times out after RISE_WAIT cycles, sent_count=1.
REQ-039 Reset mid-operation: queue 4 bytes, assert rst during WAIT_FALL -> fifo_count=0, start=0, sent_count=0, no further start pulses.
REQ-040 Wrap: preload sent_count to 0xFFFF by forcing, send one byte -> sent_count=0x0000.
